// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration target: register map,
// frame geometry, FSM state encoding and the frame acceptance rule.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;
  localparam int CNT_W      = 5;

  // Bit count of a complete frame, typed to match the frame counter
  localparam logic [CNT_W-1:0] FRAME_CNT = 5'd16;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // A frame is committed only when it is exactly 16 bits long, never
  // overran, is a write, and targets an address within range.
  function automatic logic frame_ok(input logic [CNT_W-1:0] count,
                                    input logic overflow,
                                    input logic [FRAME_BITS-1:0] frame,
                                    input logic [6:0] max_addr);
    return (count == FRAME_CNT) && !overflow && frame[15] &&
           (frame[14:8] <= max_addr);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall pulses
// derived from the final stage and one extra history flop.
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              last_reg;

  // Synchroniser chain plus history flop; both reset to the pin's idle level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
      last_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      last_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = sync_reg[STAGES-1] & ~last_reg;
  assign fall  = ~sync_reg[STAGES-1] & last_reg;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target: deserialises 16-bit frames and commits
// valid writes into five 8-bit configuration registers.
module spi_peripheral
  import spi_cfg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  logic sclk_rise;
  logic sclk_level_unused, sclk_fall_unused;
  logic copi_level;
  logic copi_rise_unused, copi_fall_unused;
  logic ncs_level, ncs_rise;
  logic ncs_fall_unused;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sclk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (copi),
    .level (copi_level),
    .rise  (copi_rise_unused),
    .fall  (copi_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ncs),
    .level (ncs_level),
    .rise  (ncs_rise),
    .fall  (ncs_fall_unused)
  );

  state_t                  state_reg, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]        count_reg, count_next;
  logic                    overflow_reg, overflow_next;
  logic                    commit;
  logic                    wr_strobe_reg;

  // Next-state logic: frame capture, overflow tracking and commit decision
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    commit        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Starting on the low level (a superset of the falling edge) also
        // picks up a select that dropped while we were in COMMIT.
        if (!ncs_level) begin
          state_next    = SHIFT;
          shift_next    = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      end
      SHIFT: begin
        // Deselect takes priority over a coincident sclk edge
        if (ncs_rise) begin
          state_next = COMMIT;
        end else if (sclk_rise) begin
          shift_next = {shift_reg[FRAME_BITS-2:0], copi_level};
          if (count_reg == FRAME_CNT) begin
            overflow_next = 1'b1;
          end else begin
            count_next = count_reg + 5'd1;
          end
        end
      end
      COMMIT: begin
        commit     = frame_ok(count_reg, overflow_reg, shift_reg, MAX_ADDR);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM and frame-capture registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      wr_strobe_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      wr_strobe_reg <= commit;
    end
  end

  // One configuration register per address; each loads on a commit to it
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [6:0] REG_ADDR = 7'(gi);
      logic [7:0] value;

      // Register update on an accepted write addressed here
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          value <= 8'h00;
        end else if (commit && (shift_reg[14:8] == REG_ADDR)) begin
          value <= shift_reg[7:0];
        end
      end
    end
  endgenerate

  assign en_reg_out_7_0  = g_reg[0].value;
  assign en_reg_out_15_8 = g_reg[1].value;
  assign en_reg_pwm_7_0  = g_reg[2].value;
  assign en_reg_pwm_15_8 = g_reg[3].value;
  assign pwm_duty_cycle  = g_reg[4].value;
  assign wr_strobe       = wr_strobe_reg;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: directed frames from the test plan
// followed by randomised frames, checked against a register-map model.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;

  always #5 clk = ~clk;

  spi_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [5];
  int         model_strobes = 0;
  int         seen_strobes = 0;
  logic [7:0] duty_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count every strobe pulse and log the duty register alongside it
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      seen_strobes++;
      duty_log.push_back(pwm_duty_cycle);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send nbits MSB-first; each sclk phase is ph clk periods
  task automatic drive_bits(input logic [16:0] bits, input int nbits, input int ph);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      cyc(ph);
      sclk = 1'b1;
      cyc(ph);
      sclk = 1'b0;
    end
  endtask

  task automatic drive_frame(input logic [16:0] bits, input int nbits, input int ph);
    ncs = 1'b0;
    cyc(ph);
    drive_bits(bits, nbits, ph);
    cyc(ph);
    ncs = 1'b1;
  endtask

  // Reference model: only a whole 16-bit write to 0..4 changes anything
  function automatic logic model_apply(input logic [16:0] bits, input int nbits);
    logic [6:0] addr;
    addr = bits[14:8];
    if (nbits == 16 && bits[15] == 1'b1 && addr <= 7'd4) begin
      model[addr] = bits[7:0];
      model_strobes++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_r0"}, {24'h0, en_reg_out_7_0},  {24'h0, model[0]});
    check({tag, "_r1"}, {24'h0, en_reg_out_15_8}, {24'h0, model[1]});
    check({tag, "_r2"}, {24'h0, en_reg_pwm_7_0},  {24'h0, model[2]});
    check({tag, "_r3"}, {24'h0, en_reg_pwm_15_8}, {24'h0, model[3]});
    check({tag, "_r4"}, {24'h0, pwm_duty_cycle},  {24'h0, model[4]});
  endtask

  // Strobe must appear exactly on the 4th sampled cycle after ncs rises
  task automatic check_strobe_window(input string tag, input logic accepted);
    logic [8:1] pat;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      pat[i] = wr_strobe;
    end
    check({tag, "_strobe"}, {24'h0, pat}, accepted ? 32'h08 : 32'h00);
  endtask

  task automatic frame_checked(input string tag, input logic [16:0] bits,
                               input int nbits, input int ph);
    logic acc;
    drive_frame(bits, nbits, ph);
    acc = model_apply(bits, nbits);
    check_strobe_window(tag, acc);
    check_regs(tag);
    $display("frame %s bits=%0h n=%0d ph=%0d accepted=%0b", tag, bits, nbits, ph, acc);
  endtask

  initial begin
    int         base;
    logic [16:0] rbits;
    int         rn, rph, sel;

    foreach (model[i]) model[i] = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    cyc(5);
    check_regs("reset");
    check("reset_strobe", {31'h0, wr_strobe}, 32'h0);
    rst_n = 1'b1;
    cyc(4);

    // Basic write and one write per remaining address
    frame_checked("basic",  17'h080F0, 16, 5);
    frame_checked("addr1",  17'h08155, 16, 5);
    frame_checked("addr2",  17'h082AA, 16, 5);
    frame_checked("addr3",  17'h083FF, 16, 5);
    frame_checked("addr4",  17'h08480, 16, 5);

    // Rejected frames: read, out of range, short, long
    frame_checked("read",   17'h000FF, 16, 5);
    frame_checked("oor",    17'h08533, 16, 5);
    frame_checked("short",  17'h04078, 15, 5);
    frame_checked("long",   17'h101E1, 17, 5);

    // Reset after 8 bits, released with ncs still low, then finish the frame
    ncs = 1'b0;
    cyc(5);
    drive_bits(17'h00080, 8, 5);
    rst_n = 1'b0;
    cyc(3);
    foreach (model[i]) model[i] = 8'h00;
    rst_n = 1'b1;
    cyc(5);
    drive_bits(17'h000F0, 8, 5);
    cyc(5);
    ncs = 1'b1;
    check_strobe_window("midrst", 1'b0);
    check_regs("midrst");
    $display("frame midrst partial frame after reset discarded");
    frame_checked("after_rst", 17'h080F0, 16, 5);

    // Back-to-back writes with the minimum ncs high time
    base = seen_strobes;
    duty_log.delete();
    drive_frame(17'h08401, 16, 3);
    void'(model_apply(17'h08401, 16));
    cyc(3);
    drive_frame(17'h08402, 16, 3);
    void'(model_apply(17'h08402, 16));
    cyc(8);
    check("b2b_count", seen_strobes - base, 32'd2);
    check("b2b_first",  (duty_log.size() > 0) ? {24'h0, duty_log[0]} : 32'hFFFF, 32'h01);
    check("b2b_second", (duty_log.size() > 1) ? {24'h0, duty_log[1]} : 32'hFFFF, 32'h02);
    check_regs("b2b");
    $display("frame b2b duty writes 01 then 02");

    // Randomised frames
    for (int n = 0; n < 40; n++) begin
      rph = $urandom_range(3, 6);
      sel = $urandom_range(0, 5);
      rbits = 17'($urandom);
      if (sel == 0) begin
        rn = 15;
        rbits[16:15] = 2'b00;
      end else if (sel == 1) begin
        rn = 17;
      end else begin
        rn = 16;
        rbits[16] = 1'b0;
        if ($urandom_range(0, 3) != 0) rbits[14:8] = 7'($urandom_range(0, 5));
      end
      frame_checked($sformatf("rnd%0d", n), rbits, rn, rph);
    end

    check("total_strobes", seen_strobes, model_strobes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
